// File: rtl/axis_bridge_pkg.sv
// axis_bridge_pkg: shared FSM states, command opcodes and bank-index width for the AXIS/BRAM bridge.
package axis_bridge_pkg;
  localparam int BANK_W = 8;
  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ = 1'b1;
  typedef enum logic [2:0] {IDLE, WR_XFER, RD_HDR, RD_XFER, RD_DRAIN, DONE} state_t;
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry in-order buffer; entry 0 is the head presented downstream.
module axis_skid_buffer #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] m0_q, m0_d, m1_q, m1_d;
  logic [1:0] cnt_q, cnt_d;
  assign dout = m0_q;
  assign count = cnt_q;
  always_comb begin
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    m0_d = pop ? m1_q : m0_q;
    m1_d = m1_q;
    if (push && cnt_q - 2'(pop) == 2'd0) m0_d = din;
    else if (push) m1_d = din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_q <= '0;
      m1_q <= '0;
      cnt_q <= '0;
    end else begin
      m0_q <= m0_d;
      m1_q <= m1_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/axis_bram_bridge.sv
// axis_bram_bridge: moves AXI-stream words into banked BRAMs and streams BRAM contents back out.
// Define AXIS_BRAM_BRIDGE_HDR_EN to compile in header-word injection ahead of read data.
module axis_bram_bridge
  import axis_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int WR_BANKS   = 16,
  parameter int RD_BANKS   = 8,
  parameter int HDR_WORDS  = 6
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_op,
  input  logic [BANK_W-1:0]               cmd_bank_start,
  input  logic [BANK_W-1:0]               cmd_bank_end,
  input  logic [ADDR_WIDTH-1:0]           cmd_addr_start,
  input  logic [15:0]                     cmd_addr_count,
  input  logic                            cmd_hdr_en,
  input  logic [HDR_WORDS*DATA_WIDTH-1:0] hdr_data_flat,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [DATA_WIDTH-1:0]           bram_wr_data,
  output logic [ADDR_WIDTH-1:0]           bram_wr_addr,
  output logic [WR_BANKS-1:0]             bram_wr_en,
  output logic [ADDR_WIDTH-1:0]           bram_rd_addr,
  output logic                            bram_rd_en,
  input  logic [RD_BANKS*DATA_WIDTH-1:0]  bram_rd_data_flat,
  output logic                            done,
  output logic                            cmd_err,
  output logic                            busy
);
  state_t state_q, state_d;
  logic [BANK_W-1:0] bank_q, bank_d, bank_end_q, bank_end_d, pend_bank_q, pend_bank_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_start_q, addr_start_d;
  logic [15:0] count_q, count_d, cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pend_word_q, pend_word_d;
  logic pend_q, pend_d, pend_hdr_q, pend_hdr_d, pend_last_q, pend_last_d, err_q, err_d;
  logic [1:0] sb_cnt;
  logic [DATA_WIDTH:0] sb_din, sb_dout;
  logic wr_fire, sb_pop, slot_free, word_last, bank_last, bad_cmd, unused_in;
`ifdef AXIS_BRAM_BRIDGE_HDR_EN
  logic [HDR_WORDS*DATA_WIDTH-1:0] hdr_q, hdr_d;
  logic [7:0] hdr_idx_q, hdr_idx_d;
  assign unused_in = s_axis_tlast;
`else
  assign unused_in = ^{s_axis_tlast, cmd_hdr_en, hdr_data_flat};
`endif
  assign wr_fire = state_q == WR_XFER && s_axis_tvalid;
  assign sb_pop = m_axis_tvalid && m_axis_tready;
  // a request issued now lands next cycle, so count what the buffer will hold by then
  assign slot_free = 3'(sb_cnt) + 3'(pend_q) - 3'(sb_pop) < 3'd2;
  assign word_last = cnt_q == count_q - 16'd1;
  assign bank_last = bank_q == bank_end_q;
  assign bad_cmd = cmd_bank_end < cmd_bank_start || cmd_addr_count == 16'd0 ||
                   32'(cmd_bank_end) >= 32'(cmd_op == OP_READ ? RD_BANKS : WR_BANKS);
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign cmd_err = err_q;
  assign s_axis_tready = state_q == WR_XFER;
  assign bram_wr_en = wr_fire ? WR_BANKS'(1) << bank_q : '0;
  assign bram_wr_data = wr_fire ? s_axis_tdata : '0;
  assign bram_wr_addr = addr_q;
  assign bram_rd_addr = addr_q;
  assign bram_rd_en = state_q == RD_XFER && slot_free;
  assign sb_din = {pend_last_q, pend_hdr_q ? pend_word_q : bram_rd_data_flat[pend_bank_q*DATA_WIDTH +: DATA_WIDTH]};
  assign m_axis_tvalid = sb_cnt != 2'd0;
  assign m_axis_tdata = sb_dout[DATA_WIDTH-1:0];
  assign m_axis_tlast = sb_dout[DATA_WIDTH];
  always_comb begin
    state_d = state_q;
    bank_d = bank_q;
    bank_end_d = bank_end_q;
    addr_d = addr_q;
    addr_start_d = addr_start_q;
    count_d = count_q;
    cnt_d = cnt_q;
    pend_d = 1'b0;
    pend_hdr_d = 1'b0;
    pend_last_d = 1'b0;
    pend_bank_d = bank_q;
    pend_word_d = pend_word_q;
    err_d = 1'b0;
`ifdef AXIS_BRAM_BRIDGE_HDR_EN
    hdr_d = hdr_q;
    hdr_idx_d = hdr_idx_q;
`endif
    case (state_q)
      IDLE: if (cmd_valid) begin
        err_d = bad_cmd;
        if (!bad_cmd) begin
          bank_d = cmd_bank_start;
          bank_end_d = cmd_bank_end;
          addr_d = cmd_addr_start;
          addr_start_d = cmd_addr_start;
          count_d = cmd_addr_count;
          cnt_d = '0;
`ifdef AXIS_BRAM_BRIDGE_HDR_EN
          hdr_d = hdr_data_flat;
          hdr_idx_d = '0;
          state_d = cmd_op == OP_WRITE ? WR_XFER : cmd_hdr_en ? RD_HDR : RD_XFER;
`else
          state_d = cmd_op == OP_WRITE ? WR_XFER : RD_XFER;
`endif
        end
      end
`ifdef AXIS_BRAM_BRIDGE_HDR_EN
      RD_HDR: if (slot_free) begin
        pend_d = 1'b1;
        pend_hdr_d = 1'b1;
        pend_word_d = hdr_q[hdr_idx_q*DATA_WIDTH +: DATA_WIDTH];
        hdr_idx_d = hdr_idx_q + 8'd1;
        state_d = hdr_idx_q == 8'(HDR_WORDS-1) ? RD_XFER : RD_HDR;
      end
`endif
      RD_DRAIN: state_d = !pend_q && sb_cnt == 2'd0 ? DONE : RD_DRAIN;
      DONE: state_d = IDLE;
      default: ;
    endcase
    if (wr_fire || bram_rd_en) begin
      cnt_d = word_last ? '0 : cnt_q + 16'd1;
      addr_d = word_last ? addr_start_q : addr_q + ADDR_WIDTH'(1);
      bank_d = word_last && !bank_last ? bank_q + BANK_W'(1) : bank_q;
      if (word_last && bank_last) state_d = state_q == WR_XFER ? DONE : RD_DRAIN;
      pend_d = bram_rd_en;
      pend_last_d = bram_rd_en && word_last && bank_last;
    end
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      bank_q <= '0;
      bank_end_q <= '0;
      pend_bank_q <= '0;
      addr_q <= '0;
      addr_start_q <= '0;
      count_q <= '0;
      cnt_q <= '0;
      pend_word_q <= '0;
      pend_q <= 1'b0;
      pend_hdr_q <= 1'b0;
      pend_last_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q <= bank_d;
      bank_end_q <= bank_end_d;
      pend_bank_q <= pend_bank_d;
      addr_q <= addr_d;
      addr_start_q <= addr_start_d;
      count_q <= count_d;
      cnt_q <= cnt_d;
      pend_word_q <= pend_word_d;
      pend_q <= pend_d;
      pend_hdr_q <= pend_hdr_d;
      pend_last_q <= pend_last_d;
      err_q <= err_d;
    end
  end
`ifdef AXIS_BRAM_BRIDGE_HDR_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      hdr_q <= '0;
      hdr_idx_q <= '0;
    end else begin
      hdr_q <= hdr_d;
      hdr_idx_q <= hdr_idx_d;
    end
  end
`endif
  axis_skid_buffer #(.W(DATA_WIDTH + 1)) u_skid (
    .clk(aclk),
    .rst(areset),
    .push(pend_q),
    .pop(sb_pop),
    .din(sb_din),
    .dout(sb_dout),
    .count(sb_cnt)
  );
endmodule
